pss_ifft_scheduler: RTL and testbench

PSS_IFFT_SCHEDULER -- requirements
Module: pss_ifft_scheduler

---
 rtl/pss_ifft_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_pss_ifft_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pss_ifft_scheduler.sv
// PSS IFFT scheduler: maps the 62-entry PSS ROM into 128 IFFT bins per symbol and forwards the 128 output samples.
// Optional WAIT watchdog is enabled by defining PSS_SCHED_WDOG_EN.
module pss_ifft_scheduler #(
    parameter int GAP_CYC  = 16,
    parameter int WDOG_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  nid2,
    input  logic [3:0]  num_sym,
    input  logic        out_ready,
    output logic [1:0]  seq_sel,
    output logic [5:0]  seq_addr,
    input  logic [47:0] seq_data,
    output logic [47:0] fft_in_data,
    output logic        fft_in_valid,
    output logic        fft_in_last,
    input  logic        fft_in_ready,
    input  logic [47:0] ifft_data,
    input  logic        ifft_valid,
    output logic [47:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_WAIT,
        S_STREAM,
        S_GAP
    } state_t;

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    // ROM index feeding bin b: upper half of the sequence sits in bins 1..31, lower half in 97..127.
    function automatic logic [5:0] bin_addr(input logic [7:0] b);
        logic [5:0] a;
        a = 6'd0;
        if (b >= 8'd1 && b <= 8'd31) begin
            a = 6'(b + 8'd30);
        end else if (b >= 8'd97 && b <= 8'd127) begin
            a = 6'(b - 8'd97);
        end else begin
            a = 6'd0;
        end
        return a;
    endfunction

    function automatic logic bin_is_zero(input logic [7:0] b);
        return !((b >= 8'd1 && b <= 8'd31) || (b >= 8'd97 && b <= 8'd127));
    endfunction

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [5:0]         r_addr;
    logic [3:0]         r_nsym;
    logic [3:0]         r_sym;
    logic [6:0]         r_bin;
    logic [6:0]         r_samp;
    logic [GAP_W-1:0]   r_gap;
    logic [47:0]        r_fft_data;
    logic               r_fft_valid;
    logic               r_fft_last;
    logic [47:0]        r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         w_next_bin;

`ifdef PSS_SCHED_WDOG_EN
    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    logic [WD_W-1:0]    r_wdog;
    logic               r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign w_next_bin   = {1'b0, r_bin} + 8'd1;
    assign seq_sel      = r_sel;
    assign seq_addr     = r_addr;
    assign fft_in_data  = r_fft_data;
    assign fft_in_valid = r_fft_valid;
    assign fft_in_last  = r_fft_last;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign busy         = r_busy;
    assign done         = r_done;

    // Burst sequencer: all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 2'd0;
            r_addr      <= 6'd0;
            r_nsym      <= 4'd0;
            r_sym       <= 4'd0;
            r_bin       <= 7'd0;
            r_samp      <= 7'd0;
            r_gap       <= '0;
            r_fft_data  <= 48'd0;
            r_fft_valid <= 1'b0;
            r_fft_last  <= 1'b0;
            r_out_data  <= 48'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PSS_SCHED_WDOG_EN
            r_wdog      <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                        r_sel   <= (nid2 == 2'd3) ? 2'd0 : nid2;
                        r_nsym  <= (num_sym == 4'd0) ? 4'd1 : num_sym;
                        r_sym   <= 4'd0;
                    end
                end
                S_ARM: begin
                    if (out_ready) begin
                        r_state     <= S_LOAD;
                        r_bin       <= 7'd0;
                        r_fft_data  <= 48'd0;
                        r_fft_valid <= 1'b1;
                        r_fft_last  <= 1'b0;
                        r_addr      <= bin_addr(8'd1);
                    end
                end
                S_LOAD: begin
                    // seq_addr always runs one bin ahead so the ROM word is ready at the accept edge.
                    if (r_fft_valid && fft_in_ready) begin
                        if (r_bin == 7'd127) begin
                            r_fft_valid <= 1'b0;
                            r_fft_last  <= 1'b0;
                            r_state     <= S_WAIT;
`ifdef PSS_SCHED_WDOG_EN
                            r_wdog      <= '0;
`endif
                        end else begin
                            r_bin      <= r_bin + 7'd1;
                            r_fft_data <= bin_is_zero(w_next_bin) ? 48'd0 : seq_data;
                            r_fft_last <= (w_next_bin == 8'd127);
                            r_addr     <= bin_addr(w_next_bin + 8'd1);
                        end
                    end
                end
                S_WAIT: begin
                    if (ifft_valid) begin
                        r_state     <= S_STREAM;
                        r_out_data  <= ifft_data;
                        r_out_valid <= 1'b1;
                        r_samp      <= 7'd1;
                    end
`ifdef PSS_SCHED_WDOG_EN
                    else if (r_wdog == WD_W'(WDOG_CYC - 1)) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
`endif
                end
                S_STREAM: begin
                    if (ifft_valid) begin
                        r_out_data  <= ifft_data;
                        r_out_valid <= 1'b1;
                        r_samp      <= r_samp + 7'd1;
                        if (r_samp == 7'd127) begin
                            r_out_last <= 1'b1;
                            if (({1'b0, r_sym} + 5'd1) < {1'b0, r_nsym}) begin
                                r_sym   <= r_sym + 4'd1;
                                r_gap   <= '0;
                                r_state <= (GAP_CYC == 0) ? S_ARM : S_GAP;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(GAP_CYC - 1)) begin
                        r_state <= S_ARM;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pss_ifft_scheduler.sv
// Directed bench for pss_ifft_scheduler: bin mapping table, stalled loading, sample forwarding, gaps and reset.
module tb_pss_ifft_scheduler;

    localparam int GAP  = 16;
    localparam int WDOG = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  nid2 = 2'd0;
    logic [3:0]  num_sym = 4'd0;
    logic        out_ready = 1'b0;
    logic        fft_in_ready = 1'b0;
    logic [47:0] ifft_data = 48'd0;
    logic        ifft_valid = 1'b0;
    logic [1:0]  seq_sel;
    logic [5:0]  seq_addr;
    logic [47:0] seq_data;
    logic [47:0] fft_in_data;
    logic        fft_in_valid;
    logic        fft_in_last;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    function automatic logic [47:0] rom(input logic [1:0] s, input logic [5:0] a);
        return {4'hA, 12'd0, s, a, 4'h5, 12'd0, s, a};
    endfunction

    assign seq_data = rom(seq_sel, seq_addr);

    pss_ifft_scheduler #(.GAP_CYC(GAP), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst(rst), .start(start), .nid2(nid2), .num_sym(num_sym),
        .out_ready(out_ready), .seq_sel(seq_sel), .seq_addr(seq_addr), .seq_data(seq_data),
        .fft_in_data(fft_in_data), .fft_in_valid(fft_in_valid), .fft_in_last(fft_in_last),
        .fft_in_ready(fft_in_ready), .ifft_data(ifft_data), .ifft_valid(ifft_valid),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        string       name;
        int          bin;
        logic [47:0] data;
        logic        last;
    } vec_t;

    vec_t        vecs[8];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [47:0] beat_data[128];
    logic        beat_last[128];
    logic [47:0] ref_data[128];

    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic chk48(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [47:0] exp_bin(input logic [1:0] s, input int b);
        logic [47:0] v;
        v = 48'd0;
        if (b >= 1 && b <= 31) v = rom(s, 6'(b + 30));
        else if (b >= 97) v = rom(s, 6'(b - 97));
        else v = 48'd0;
        return v;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_fvalid"}, fft_in_valid, 1'b0);
        chk1({tag, "_flast"}, fft_in_last, 1'b0);
        chk48({tag, "_fdata"}, fft_in_data, 48'd0);
        chk1({tag, "_ovalid"}, out_valid, 1'b0);
        chk1({tag, "_olast"}, out_last, 1'b0);
        chk48({tag, "_odata"}, out_data, 48'd0);
        chk48({tag, "_addr"}, {42'd0, seq_addr}, 48'd0);
        chk48({tag, "_sel"}, {46'd0, seq_sel}, 48'd0);
    endtask

    task automatic do_start(input logic [1:0] n, input logic [3:0] ns);
        nid2 = n;
        num_sym = ns;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records accepted beats until 128 are seen; ends #1 after the edge accepting the last one.
    task automatic capture_load(input bit toggle);
        int  nb;
        int  guard;
        bit  rdy;
        nb = 0;
        guard = 0;
        rdy = 1'b1;
        while (nb < 128 && guard < 2000) begin
            fft_in_ready = toggle ? rdy : 1'b1;
            if (fft_in_valid && fft_in_ready) begin
                beat_data[nb] = fft_in_data;
                beat_last[nb] = fft_in_last;
                nb++;
            end
            tick();
            rdy = ~rdy;
            guard++;
        end
        fft_in_ready = 1'b0;
        chki("load_beats", nb, 128);
        chk1("load_end_valid", fft_in_valid, 1'b0);
    endtask

    task automatic check_seq(input logic [1:0] s);
        for (int k = 0; k < 128; k++) begin
            chk48($sformatf("bin%0d_data", k), beat_data[k], exp_bin(s, k));
            chk1($sformatf("bin%0d_last", k), beat_last[k], (k == 127));
        end
    endtask

    task automatic stream_sym(input int pre, input int nval, input logic [7:0] tag, input logic exp_done);
        logic [47:0] d;
        ifft_valid = 1'b0;
        for (int i = 0; i < pre; i++) tick();
        chk1("wait_out_valid", out_valid, 1'b0);
        chk1("wait_busy", busy, 1'b1);
        chk1("wait_err", err, 1'b0);
        for (int i = 0; i < nval; i++) begin
            d = {tag, 8'h00, 32'(i)};
            ifft_valid = 1'b1;
            ifft_data = d;
            tick();
            if (i < 128) begin
                chk1($sformatf("smp%0d_valid", i), out_valid, 1'b1);
                chk48($sformatf("smp%0d_data", i), out_data, d);
                chk1($sformatf("smp%0d_last", i), out_last, (i == 127));
                if (i == 127) chk1("sym_done", done, exp_done);
            end else begin
                chk1($sformatf("extra%0d_valid", i), out_valid, 1'b0);
            end
        end
        ifft_valid = 1'b0;
    endtask

    task automatic gap_measure();
        int cyc;
        bit lost;
        cyc = 0;
        lost = 1'b0;
        while (!fft_in_valid && cyc < 100) begin
            if (!busy) lost = 1'b1;
            tick();
            cyc++;
        end
        chki("gap_to_load", cyc, GAP + 1);
        chk1("gap_busy_lost", lost, 1'b0);
    endtask

    initial begin
        bit bad_v;
        bit bad_b;

        vecs[0] = '{"tbl_bin0",   0,   48'h000000_000000, 1'b0};
        vecs[1] = '{"tbl_bin1",   1,   48'hA0005F_50005F, 1'b0};
        vecs[2] = '{"tbl_bin31",  31,  48'hA0007D_50007D, 1'b0};
        vecs[3] = '{"tbl_bin32",  32,  48'h000000_000000, 1'b0};
        vecs[4] = '{"tbl_bin64",  64,  48'h000000_000000, 1'b0};
        vecs[5] = '{"tbl_bin96",  96,  48'h000000_000000, 1'b0};
        vecs[6] = '{"tbl_bin97",  97,  48'hA00040_500040, 1'b0};
        vecs[7] = '{"tbl_bin127", 127, 48'hA0005E_50005E, 1'b1};

        rst = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        rst = 1'b1;
        tick();

        // nid2=1, single symbol, ready always high, 130 IFFT samples
        out_ready = 1'b1;
        done_cnt = 0;
        do_start(2'd1, 4'd1);
        chk1("arm_busy", busy, 1'b1);
        chk48("arm_sel", {46'd0, seq_sel}, 48'd1);
        chk1("arm_no_valid", fft_in_valid, 1'b0);
        capture_load(1'b0);
        for (int v = 0; v < 8; v++) begin
            chk48({vecs[v].name, "_data"}, beat_data[vecs[v].bin], vecs[v].data);
            chk1({vecs[v].name, "_last"}, beat_last[vecs[v].bin], vecs[v].last);
        end
        check_seq(2'd1);
        for (int k = 0; k < 128; k++) ref_data[k] = beat_data[k];
        stream_sym(40, 130, 8'hA1, 1'b1);
        tick();
        chki("a_done_cnt", done_cnt, 1);
        chk1("a_idle", busy, 1'b0);

        // ready toggling, plus a start pulse mid-LOAD that must be ignored
        done_cnt = 0;
        fft_in_ready = 1'b0;
        do_start(2'd1, 4'd1);
        tick();
        nid2 = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk48("busy_start_sel", {46'd0, seq_sel}, 48'd1);
        capture_load(1'b1);
        for (int k = 0; k < 128; k++) begin
            chk48($sformatf("tog%0d_data", k), beat_data[k], ref_data[k]);
            chk1($sformatf("tog%0d_last", k), beat_last[k], (k == 127));
        end
        stream_sym(2, 128, 8'hB2, 1'b1);
        tick();
        chki("b_done_cnt", done_cnt, 1);

        // nid2=3 maps to 0, num_sym=0 maps to 1
        done_cnt = 0;
        do_start(2'd3, 4'd0);
        chk48("nid3_sel", {46'd0, seq_sel}, 48'd0);
        capture_load(1'b0);
        check_seq(2'd0);
        stream_sym(1, 128, 8'hC3, 1'b1);
        tick();
        chki("c_done_cnt", done_cnt, 1);
        chk1("c_idle", busy, 1'b0);

        // three symbols with gaps
        done_cnt = 0;
        do_start(2'd2, 4'd3);
        for (int s = 0; s < 3; s++) begin
            capture_load(1'b0);
            check_seq(2'd2);
            stream_sym(3, 128, 8'(8'hD0 + s), (s == 2));
            if (s < 2) gap_measure();
        end
        tick();
        chki("d_done_cnt", done_cnt, 1);
        chk1("d_idle", busy, 1'b0);

        // out_ready held low for 50 cycles after start
        done_cnt = 0;
        out_ready = 1'b0;
        do_start(2'd0, 4'd1);
        bad_v = 1'b0;
        bad_b = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fft_in_valid) bad_v = 1'b1;
            if (!busy) bad_b = 1'b1;
        end
        chk1("arm_hold_valid", bad_v, 1'b0);
        chk1("arm_hold_busy", bad_b, 1'b0);
        out_ready = 1'b1;
        chk1("arm_pre_rise", fft_in_valid, 1'b0);
        tick();
        chk1("arm_load_start", fft_in_valid, 1'b1);
        capture_load(1'b0);
        check_seq(2'd0);

        // reset in the middle of STREAM
        for (int i = 0; i < 40; i++) begin
            ifft_valid = 1'b1;
            ifft_data = {8'hE5, 8'h00, 32'(i)};
            tick();
            chk1($sformatf("part%0d_valid", i), out_valid, 1'b1);
        end
        rst = 1'b0;
        tick();
        chk_reset_outputs("mid_rst");
        rst = 1'b1;
        bad_v = 1'b0;
        bad_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid || out_last) bad_v = 1'b1;
            if (busy) bad_b = 1'b1;
        end
        ifft_valid = 1'b0;
        chk1("post_rst_out", bad_v, 1'b0);
        chk1("post_rst_busy", bad_b, 1'b0);
        chki("post_rst_done", done_cnt, 0);
        do_start(2'd1, 4'd1);
        capture_load(1'b0);
        check_seq(2'd1);
        stream_sym(1, 128, 8'hF6, 1'b1);
        tick();
        chki("e_done_cnt", done_cnt, 1);

`ifdef PSS_SCHED_WDOG_EN
        // watchdog: no IFFT output ever arrives
        done_cnt = 0;
        do_start(2'd1, 4'd1);
        capture_load(1'b0);
        ifft_valid = 1'b0;
        repeat (WDOG - 1) tick();
        chk1("wd_pre_err", err, 1'b0);
        chk1("wd_pre_busy", busy, 1'b1);
        tick();
        chk1("wd_err", err, 1'b1);
        chk1("wd_busy", busy, 1'b0);
        repeat (5) tick();
        chk1("wd_sticky", err, 1'b1);
        chki("wd_no_done", done_cnt, 0);
`else
        chk1("no_wdog_err", err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
